// File: rtl/answer_switch_rx.sv
// answer_switch_rx
//   Front end for the quiz answer switches. Each raw switch is synchronised
//   (two flops), debounced against the tick strobe, and a clean single press
//   becomes a held token (valid + choice) until the game core acks it.
//   Multi-switch presses raise a one-cycle conflict pulse; after any token
//   or conflict, further presses are ignored until all switches are released.
//
// Ports
//   clk      in  system clock, rising edge
//   reset    in  asynchronous active-high reset
//   tick     in  debounce sample strobe (one clk wide)
//   switch   in  [3:0] raw switches: 0=add 1=sub 2=mul 3=skip
//   ack      in  consumer accepts the current token (ignored unless valid)
//   valid    out token available, held until acked
//   choice   out [1:0] index of the pressed switch
//   conflict out one-cycle pulse on a rejected multi-switch press
//   pressed  out [3:0] debounced stable switch levels
module answer_switch_rx #(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] switch,
    input  logic       ack,
    output logic       valid,
    output logic [1:0] choice,
    output logic       conflict,
    output logic [3:0] pressed
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_REL
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_TICKS - 1);

    logic [3:0]      s1_q;
    logic [3:0]      s2_q;
    logic [3:0]      stb_q, stb_d;
    logic [3:0]      stb_prev_q;
    logic [3:0][7:0] cnt_q, cnt_d;
    logic [3:0]      rise;
    logic            one_hot;
    logic            multi;
    logic [1:0]      index;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [1:0]      choice_q, choice_d;
    logic            conflict_q, conflict_d;

    // Debounce: stb flips only after DEBOUNCE_TICKS consecutive ticks on
    // which the synchronised level disagreed with it.
    always_comb begin
        stb_d = stb_q;
        cnt_d = cnt_q;
        if (tick) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (s2_q[i] != stb_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        stb_d[i] = ~stb_q[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    always_comb begin
        rise    = stb_q & ~stb_prev_q;
        one_hot = (stb_q != '0) && ((stb_q & (stb_q - 4'd1)) == '0);
        multi   = (stb_q != '0) && !one_hot;
        index   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (stb_q[i]) begin
                index = 2'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        choice_d   = choice_q;
        conflict_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise != '0) begin
                    if (one_hot) begin
                        state_d  = HOLD;
                        valid_d  = 1'b1;
                        choice_d = index;
                    end else if (multi) begin
                        state_d    = WAIT_REL;
                        conflict_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Rises arriving here (even with ack) are dropped.
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = (stb_q != '0) ? WAIT_REL : IDLE;
                end
            end
            WAIT_REL: begin
                if (stb_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            stb_q      <= '0;
            stb_prev_q <= '0;
            cnt_q      <= '0;
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            choice_q   <= '0;
            conflict_q <= 1'b0;
        end else begin
            s1_q       <= switch;
            s2_q       <= s1_q;
            stb_q      <= stb_d;
            stb_prev_q <= stb_q;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            valid_q    <= valid_d;
            choice_q   <= choice_d;
            conflict_q <= conflict_d;
        end
    end

    assign valid    = valid_q;
    assign choice   = choice_q;
    assign conflict = conflict_q;
    assign pressed  = stb_q;

endmodule
